// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared states and bus constants for the I2C EEPROM target
`timescale 1ns/1ps
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_AH,
        ST_AH_ACK,
        ST_AL,
        ST_AL_ACK,
        ST_WDATA,
        ST_W_ACK,
        ST_RDATA,
        ST_R_MACK
    } i2c_state_e;

    // Upper nibble of the 7-bit device address for the 24Cxx family.
    localparam logic [3:0] DEV_TYPE = 4'b1010;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge, START and STOP strobes
// Ports: clk, rst_n (async, active low); scl_in/sda_in raw pads;
//        scl_rise/scl_fall/start_det/stop_det one-cycle strobes; sda_s synchronized SDA.
`timescale 1ns/1ps
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;

    // Two sync flops, one history flop, then registered strobes: a pad
    // change reaches the strobes three clocks later.  Idle bus is high,
    // so everything resets to 1 to avoid a phantom edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl_in};
            sda_sync  <= {sda_sync[0], sda_in};
            scl_q     <= scl_sync[1];
            sda_q     <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_q;
            scl_fall  <= ~scl_sync[1] & scl_q;
            // SDA edges only count as START/STOP when SCL is stably high.
            start_det <= scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
            sda_s     <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - I2C target emulating a 24Cxx EEPROM with two-byte word addressing
// Optional feature macro: I2C_SLAVE_PAGE_WRAP_EN (write pointer rolls over within its page).
// Ports: clk, rst_n (async, active low); i_slave_addr A2..A0 straps; i_i2c_scl bus clock;
//        io_i2c_sda open-drain data; o_busy addressed-transfer flag;
//        o_wr_strobe/o_wr_addr/o_wr_data report each committed write byte.
`timescale 1ns/1ps
module i2c_eeprom_slave
    import i2c_slave_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 16,
    parameter int P_MEM_AW     = 8,
    parameter int P_PAGE_SIZE  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              i_slave_addr,
    input  logic                    i_i2c_scl,
    inout  wire                     io_i2c_sda,
    output logic                    o_busy,
    output logic                    o_wr_strobe,
    output logic [P_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [7:0]              o_wr_data
);

    localparam int PAGE_BITS = $clog2(P_PAGE_SIZE);

`ifdef I2C_SLAVE_PAGE_WRAP_EN
    localparam bit PAGE_WRAP = 1'b1;
`else
    localparam bit PAGE_WRAP = 1'b0;
`endif

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (i_i2c_scl),
        .sda_in    (io_i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e              state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_q, shift_d;
    logic [P_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    mack_q, mack_d;
    logic                    busy_d, wr_strobe_d;
    logic [P_ADDR_WIDTH-1:0] wr_addr_d;
    logic [7:0]              wr_data_d;

    logic [7:0]              mem [0:(1<<P_MEM_AW)-1];
    logic                    mem_we;
    logic [7:0]              rx_byte;
    logic [6:0]              dev_addr;
    logic [P_ADDR_WIDTH-1:0] ptr_inc, ptr_page_inc, ptr_wr_inc;
    logic [7:0]              mem_rd_cur, mem_rd_nxt;

    assign dev_addr   = {DEV_TYPE, i_slave_addr};
    assign rx_byte    = {shift_q[6:0], sda_s};
    assign ptr_inc    = ptr_q + P_ADDR_WIDTH'(1);
    assign ptr_page_inc = {ptr_q[P_ADDR_WIDTH-1:PAGE_BITS], ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
    assign ptr_wr_inc = PAGE_WRAP ? ptr_page_inc : ptr_inc;
    assign mem_rd_cur = mem[ptr_q[P_MEM_AW-1:0]];
    assign mem_rd_nxt = mem[ptr_inc[P_MEM_AW-1:0]];

    // Only ever pull low; the async reset of sda_oe_q releases the line at once.
    assign io_i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            mack_q      <= 1'b0;
            o_busy      <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            mack_q      <= mack_d;
            o_busy      <= busy_d;
            o_wr_strobe <= wr_strobe_d;
            o_wr_addr   <= wr_addr_d;
            o_wr_data   <= wr_data_d;
        end
    end

    // The array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[P_MEM_AW-1:0]] <= rx_byte;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        mack_d      = mack_q;
        busy_d      = o_busy;
        wr_strobe_d = 1'b0;
        wr_addr_d   = o_wr_addr;
        wr_data_d   = o_wr_data;
        mem_we      = 1'b0;

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            // Pointer deliberately kept so a repeated START gives a random read.
            state_d   = ST_DEV;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_DEV, ST_AH, ST_AL, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ST_AH) begin
                                ptr_d[15:8] = rx_byte;
                            end else if (state_q == ST_AL) begin
                                ptr_d[7:0] = rx_byte;
                            end else if (state_q == ST_WDATA) begin
                                mem_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_wr_inc;
                            end
                        end
                    end
                    // ACK starts on the fall that ends bit 8.
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_DEV && shift_q[7:1] != dev_addr) begin
                            state_d = ST_IDLE;
                        end else begin
                            sda_oe_d = (ACK_BIT == 1'b0);
                            case (state_q)
                                ST_DEV: begin
                                    state_d = ST_DEV_ACK;
                                    busy_d  = 1'b1;
                                end
                                ST_AH:   state_d = ST_AH_ACK;
                                ST_AL:   state_d = ST_AL_ACK;
                                default: state_d = ST_W_ACK;
                            endcase
                        end
                    end
                end

                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        // shift_q[0] still holds R/W: ACK states never shift.
                        if (shift_q[0]) begin
                            shift_d  = mem_rd_cur;
                            sda_oe_d = ~mem_rd_cur[7];
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_AH;
                        end
                        bit_cnt_d = 4'd0;
                    end
                end

                ST_AH_ACK, ST_AL_ACK, ST_W_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = (state_q == ST_AH_ACK) ? ST_AL : ST_WDATA;
                    end
                end

                ST_RDATA: begin
                    // Bit 7 went out on entry; each fall advances one bit, the
                    // eighth fall hands the line to the master for its ACK.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_R_MACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ST_R_MACK: begin
                    if (scl_rise) begin
                        mack_d = (sda_s == ACK_BIT);
                    end
                    if (scl_fall) begin
                        if (mack_q) begin
                            ptr_d    = ptr_inc;
                            shift_d  = mem_rd_nxt;
                            sda_oe_d = ~mem_rd_nxt[7];
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = (NACK_BIT == 1'b0);
                            state_d  = ST_IDLE;
                        end
                        bit_cnt_d = 4'd0;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb/tb_i2c_eeprom_slave.sv - directed scoreboard bench for i2c_eeprom_slave
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  straps = 3'b101;
    logic        scl = 1'b1;
    logic        m_sda_oe = 1'b0;
    wire         sda;
    logic        busy;
    logic        wr_strobe;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  mdl[int];
    logic        watch_z = 1'b0;
    logic        dut_drove = 1'b0;

    pullup (sda);
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_eeprom_slave dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_slave_addr (straps),
        .i_i2c_scl    (scl),
        .io_i2c_sda   (sda),
        .o_busy       (busy),
        .o_wr_strobe  (wr_strobe),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            check("strobe_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(wr_q.pop_front()));
            end
        end
        if (watch_z && !m_sda_oe && sda === 1'b0) begin
            dut_drove = 1'b1;
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] next_wr(input logic [15:0] p);
`ifdef I2C_SLAVE_PAGE_WRAP_EN
        return {p[15:5], p[4:0] + 5'd1};
`else
        return p + 16'd1;
`endif
    endfunction

    // One bus bit: b=1 releases SDA. Returns SDA sampled mid SCL-high.
    task automatic bus_bit(input logic b, output logic s);
        m_sda_oe = ~b;
        #100 scl = 1'b1;
        #100 s = sda;
        #100 scl = 1'b0;
        #100;
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0;
        #100 scl = 1'b1;
        #100 m_sda_oe = 1'b1;
        #100 scl = 1'b0;
        #100;
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1;
        #100 scl = 1'b1;
        #100 m_sda_oe = 1'b0;
        #100;
    endtask

    task automatic write_byte(input logic [7:0] b, input string tag, input logic exp_ack_bit);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        check(tag, 32'(s), 32'(exp_ack_bit));
    endtask

    task automatic read_byte(input logic mack, input string tag);
        logic       s;
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            r = {r[6:0], s};
        end
        bus_bit(~mack, s);
        check({tag, "_pending"}, 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check(tag, 32'(r), 32'(rd_q.pop_front()));
    endtask

    task automatic eeprom_write(input logic [15:0] a, input int n,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [15:0] p = a;
        logic [7:0]  d;
        bus_start();
        write_byte(8'hAA, "w_dev_ack", 1'b0);
        write_byte(a[15:8], "w_ah_ack", 1'b0);
        write_byte(a[7:0], "w_al_ack", 1'b0);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            wr_q.push_back({p, d});
            mdl[int'(p[7:0])] = d;
            write_byte(d, "w_data_ack", 1'b0);
            p = next_wr(p);
        end
        bus_stop();
    endtask

    task automatic set_pointer_restart(input logic [15:0] a);
        bus_start();
        write_byte(8'hAA, "rr_dev_ack", 1'b0);
        write_byte(a[15:8], "rr_ah_ack", 1'b0);
        write_byte(a[7:0], "rr_al_ack", 1'b0);
        bus_start();
        write_byte(8'hAB, "rr_devr_ack", 1'b0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        #200;

        eeprom_write(16'h0000, 1, 8'hC3, 8'h00, 8'h00);
        eeprom_write(16'h0013, 1, 8'h5A, 8'h00, 8'h00);
        eeprom_write(16'h0010, 3, 8'h11, 8'h22, 8'h33);

        // Current-address read: pointer left at 0x0013 by the page above.
        bus_start();
        write_byte(8'hAB, "cur_dev_ack", 1'b0);
        rd_q.push_back(mdl[8'h13]);
        read_byte(1'b0, "cur_rd");
        bus_stop();

        // Random read with ACK then NACK.
        set_pointer_restart(16'h0011);
        rd_q.push_back(8'h22);
        read_byte(1'b1, "rand_rd0");
        rd_q.push_back(8'h33);
        read_byte(1'b0, "rand_rd1");
        check("nack_released", 32'(sda), 32'd1);
        check("busy_before_stop", 32'(busy), 32'd1);
        bus_stop();
        #100;
        check("busy_after_stop", 32'(busy), 32'd0);

        // Address mismatch: no ACK, no drive, no strobe.
        watch_z = 1'b1;
        bus_start();
        write_byte(8'hA0, "mm_dev_nack", 1'b1);
        write_byte(8'h00, "mm_ah_nack", 1'b1);
        write_byte(8'h10, "mm_al_nack", 1'b1);
        write_byte(8'h55, "mm_data_nack", 1'b1);
        check("mm_busy", 32'(busy), 32'd0);
        bus_stop();
        watch_z = 1'b0;
        check("mm_sda_never_low", 32'(dut_drove), 32'd0);

        // Page roll-over (or linear increment without the macro).
        eeprom_write(16'h001F, 3, 8'hA1, 8'hB2, 8'hC4);
        set_pointer_restart(16'h001F);
        rd_q.push_back(8'hA1);
        read_byte(1'b0, "page_rd");
        bus_stop();

        // Reset while the target drives the 0 MSB of 0x22.
        set_pointer_restart(16'h0011);
        check("rd_bit_driven", 32'(sda), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_sda_async", 32'(sda), 32'd1);
        #100 rst_n = 1'b1;
        #100;
        check("post_rst_busy", 32'(busy), 32'd0);
        bus_start();
        write_byte(8'hAB, "post_rst_dev_ack", 1'b0);
        rd_q.push_back(mdl[0]);
        read_byte(1'b0, "post_rst_rd");
        bus_stop();

        #1000;
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
